regfile: RTL
============

Name: regfile

Overview:
- MIPS general-purpose register file, 32 x 32-bit.
- Sits at the consumer end of the result path that execute produces. Execute's write-enable, write-address and result travel through the mem and wb pipeline registers and land here as the write port.
- Two read ports feed the decode stage's source operands.
- Includes write-to-read bypass, so decode sees a value written back in the same cycle.

Parameters:
- DATA_W, 32, register width in bits (matches `RegDataBus`).
- ADDR_W, 5, register address width (matches `RegAddrBus`).
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- we  input  1  write enable from the wb stage.
- waddr  input  ADDR_W  write register index.
- wdata  input  DATA_W  write data.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 index.
- rdata1  output  DATA_W  read port 1 data (combinational).
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 index.
- rdata2  output  DATA_W  read port 2 data (combinational).

Behaviour:
- Reset (rst low, asynchronous): every register clears to `ZeroWord` immediately. rdata1 and rdata2 read `ZeroWord` while rst is low, regardless of the other inputs.
- Deassertion: the first write can occur on the first rising clk edge after rst goes high.
- Write: on posedge clk, when rst is high and we=1 and waddr != 0, reg[waddr] <= wdata.
  - Writes to index 0 are discarded; $zero stays 0 forever.
  - we=0 leaves all registers unchanged.
- Read port n (identical for both ports), priority order:
  1. rst low -> 0.
  2. ren=0 -> 0.
  3. raddrn==0 -> 0.
  4. we=1 and waddr==raddrn -> wdata (same-cycle bypass).
  5. Otherwise -> reg[raddrn].
- Read latency: 0 cycles (purely combinational from the address, enable and bypass inputs). A written value is visible through storage from the cycle after the write edge.
- Both ports may read the same index simultaneously; both return identical data, including the bypass case.
- Register state is not affected by read activity.
- No X on outputs after reset, for any input combination.

Optional Feature:
- Macro: REGFILE_DEBUG_EN.
- When defined, adds the following ports:
  - dbg_addr  input  ADDR_W  debug read index.
  - dbg_data  output  DATA_W  registered debug read data.
  - wr_count  output  32  count of committed writes.
- dbg_data behaviour:
  - Updates on posedge clk to reg[dbg_addr] as stored before that edge's write (no bypass).
  - Reads 0 for dbg_addr==0.
  - Resets to 0.
- wr_count behaviour:
  - Increments by 1 on each posedge where we=1 and waddr != 0.
  - Wraps from 0xFFFFFFFF to 0.
  - Resets to 0.
- When not defined: these ports and their logic are absent; the main behaviour is identical.

Test Plan:
- Reset and zero register:
  - Assert rst=0 mid-run after writing reg5=0x12345678 -> rdata1 (raddr1=5, re1=1) reads 0x00000000 immediately.
  - Release rst, read reg5 -> 0x00000000.
- Write/read ordering:
  - we=1, waddr=3, wdata=0xDEADBEEF at edge N; re1=1, raddr1=3 at N+1 with we=0 -> rdata1=0xDEADBEEF.
  - re2=0, raddr2=3 -> rdata2=0x00000000.
- Bypass:
  - reg7=0x00000001 stored; same cycle we=1, waddr=7, wdata=0x000000FF, raddr1=raddr2=7, re1=re2=1 -> rdata1=rdata2=0x000000FF before the edge.
  - After the edge with we=0 -> both still read 0x000000FF.
- $zero protection:
  - we=1, waddr=0, wdata=0xFFFFFFFF for 3 cycles -> rdata1 with raddr1=0 reads 0x00000000 during and after, with no bypass.
  - With REGFILE_DEBUG_EN defined -> wr_count unchanged.
- Full sweep:
  - Write reg[i]=i*0x01010101 for i=1..31, then read all on both ports -> every value matches.
  - Index 0 reads 0.
- Debug build (REGFILE_DEBUG_EN):
  - 31 writes from reset -> wr_count=31.
  - dbg_addr=4 -> dbg_data=0x04040404 one cycle later.

Source files
------------

// File: rtl/regfile.sv
// MIPS general-purpose register file: 32 x 32-bit, one write port, two
// combinational read ports with same-cycle write-to-read bypass.
// Optional debug port and write counter enabled by defining REGFILE_DEBUG_EN.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wr_count
`endif
);

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic                            wr_commit;

    // A write only lands when enabled and not aimed at $zero.
    assign wr_commit = we && (waddr != '0);

    // Storage: entry 0 is never written, so $zero stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else if (wr_commit) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1: reset, enable and $zero mask, then bypass, then storage.
    always_comb begin
        rdata1 = ZERO_WORD;
        if (rst && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) rdata1 = wdata;
            else                         rdata1 = regs[raddr1];
        end
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        rdata2 = ZERO_WORD;
        if (rst && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) rdata2 = wdata;
            else                         rdata2 = regs[raddr2];
        end
    end

`ifdef REGFILE_DEBUG_EN
    // Debug read samples storage before this edge's write; entry 0 is always zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dbg_data <= '0;
        else      dbg_data <= regs[dbg_addr];
    end

    // Count committed writes; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           wr_count <= '0;
        else if (wr_commit) wr_count <= wr_count + 32'd1;
    end
`endif

endmodule
